// File: rtl/prog_signal_delay.sv
// prog_signal_delay: runtime-programmable valid-tagged delay line with stall, flush and settle suppression
module prog_signal_delay #(
    parameter int SIGNAL_WIDTH = 4,
    parameter int MAX_DELAY    = 8,
    parameter int DW           = $clog2(MAX_DELAY + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    flush,
    input  logic [DW-1:0]           delay_sel,
    input  logic                    in_valid,
    input  logic [SIGNAL_WIDTH-1:0] in_data,
    output logic                    out_valid,
    output logic [SIGNAL_WIDTH-1:0] out_data,
    output logic [DW-1:0]           cur_delay,
    output logic                    settling,
    output logic                    delay_err
);
    typedef enum logic {RUN, SETTLE} state_t;
    state_t                  state_q, state_d;
    logic [SIGNAL_WIDTH-1:0] stage_q [1:MAX_DELAY];
    logic [SIGNAL_WIDTH-1:0] stage_d [1:MAX_DELAY];
    logic [MAX_DELAY:1]      vstg_q, vstg_d;
    logic [DW-1:0]           cur_delay_q, cur_delay_d, settle_cnt_q, settle_cnt_d, sel_c;
    logic                    delay_err_q, delay_err_d, chg, shift;
    assign sel_c = (delay_sel > DW'(MAX_DELAY)) ? DW'(MAX_DELAY) : delay_sel;
    assign chg   = sel_c != cur_delay_q;
    assign shift = en && !chg && !flush;
    always_comb begin
        stage_d      = stage_q;
        vstg_d       = vstg_q;
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        cur_delay_d  = chg ? sel_c : cur_delay_q;
        delay_err_d  = delay_sel > DW'(MAX_DELAY);
        if (shift) begin
            stage_d[1] = in_data;
            vstg_d[1]  = in_valid;
            for (int k = 2; k <= MAX_DELAY; k++) begin
                stage_d[k] = stage_q[k-1];
                vstg_d[k]  = vstg_q[k-1];
            end
        end
        if (chg || flush) vstg_d = '0;
        // a delay change restarts settling; flush freezes the settle count
        if (chg) begin
            settle_cnt_d = sel_c;
            state_d      = (sel_c != '0) ? SETTLE : RUN;
        end else if (state_q == SETTLE && en && !flush) begin
            settle_cnt_d = settle_cnt_q - DW'(1);
            state_d      = (settle_cnt_q == DW'(1)) ? RUN : SETTLE;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q      <= '{default: '0};
            vstg_q       <= '0;
            state_q      <= RUN;
            settle_cnt_q <= '0;
            cur_delay_q  <= '0;
            delay_err_q  <= 1'b0;
        end else begin
            stage_q      <= stage_d;
            vstg_q       <= vstg_d;
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            cur_delay_q  <= cur_delay_d;
            delay_err_q  <= delay_err_d;
        end
    end
    assign out_data  = (cur_delay_q == '0) ? in_data : stage_q[cur_delay_q];
    assign out_valid = rst_n && ((cur_delay_q == '0) ? in_valid : (vstg_q[cur_delay_q] && state_q == RUN));
    assign cur_delay = cur_delay_q;
    assign settling  = state_q == SETTLE;
    assign delay_err = delay_err_q;
endmodule

// File: tb/tb_prog_signal_delay.sv
// tb_prog_signal_delay: directed and random checks of prog_signal_delay against a sample-history model
module tb_prog_signal_delay;
    localparam int W  = 4;
    localparam int MD = 8;
    localparam int DW = $clog2(MD + 1);
    logic          clk = 1'b0, rst_n = 1'b0, en = 1'b0, flush = 1'b0, in_valid = 1'b0;
    logic [DW-1:0] delay_sel = '0;
    logic [W-1:0]  in_data = '0;
    logic          out_valid, settling, delay_err;
    logic [W-1:0]  out_data;
    logic [DW-1:0] cur_delay;
    int            checks = 0, errors = 0;
    typedef struct {logic v; logic [W-1:0] d;} ent_t;
    ent_t hist[$];
    int   cur_m = 0, settle_m = 0;
    logic err_m = 1'b0;
    always #5 clk = ~clk;
    prog_signal_delay #(.SIGNAL_WIDTH(W), .MAX_DELAY(MD)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .delay_sel(delay_sel),
        .in_valid(in_valid), .in_data(in_data), .out_valid(out_valid), .out_data(out_data),
        .cur_delay(cur_delay), .settling(settling), .delay_err(delay_err)
    );
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic model_reset();
        hist.delete();
        cur_m    = 0;
        settle_m = 0;
        err_m    = 1'b0;
    endtask
    // history holds every captured sample, newest first; the tap D reads the sample captured D shifts ago
    task automatic model_edge();
        int   s;
        ent_t e;
        if (!rst_n) begin
            model_reset();
            return;
        end
        s     = (int'(delay_sel) > MD) ? MD : int'(delay_sel);
        err_m = int'(delay_sel) > MD;
        if (s != cur_m) begin
            cur_m    = s;
            settle_m = s;
            foreach (hist[i]) hist[i].v = 1'b0;
        end else if (flush) begin
            foreach (hist[i]) hist[i].v = 1'b0;
        end else if (en) begin
            e.v = in_valid;
            e.d = in_data;
            hist.push_front(e);
            if (hist.size() > MD) void'(hist.pop_back());
            if (settle_m > 0) settle_m--;
        end
    endtask
    task automatic check_outputs();
        logic         ev, dchk;
        logic [W-1:0] ed;
        ed = in_data;
        if (!rst_n) ev = 1'b0;
        else if (cur_m == 0) ev = in_valid;
        else begin
            ev = settle_m == 0 && hist.size() >= cur_m && hist[cur_m-1].v;
            if (hist.size() >= cur_m) ed = hist[cur_m-1].d;
        end
        dchk = !rst_n || cur_m == 0 || ev;
        chk("out_valid", 8'(out_valid), 8'(ev));
        if (dchk) chk("out_data", 8'(out_data), 8'(ed));
        chk("cur_delay", 8'(cur_delay), 8'(cur_m));
        chk("settling", 8'(settling), 8'(settle_m > 0));
        chk("delay_err", 8'(delay_err), 8'(err_m));
    endtask
    task automatic step(input logic e, input logic f, input logic [DW-1:0] ds, input logic iv, input logic [W-1:0] id);
        en        = e;
        flush     = f;
        delay_sel = ds;
        in_valid  = iv;
        in_data   = id;
        #1 check_outputs();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask
    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1 check_outputs();
        chk("rst_out_valid", 8'(out_valid), 8'h0);
        chk("rst_settling", 8'(settling), 8'h0);
        chk("rst_cur_delay", 8'(cur_delay), 8'h0);
        chk("rst_delay_err", 8'(delay_err), 8'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask
    initial begin
        @(negedge clk);
        step(1, 0, 3, 1, 4'h5);
        step(1, 0, 3, 1, 4'h6);
        rst_n = 1'b1;
        step(1, 0, 3, 0, 4'h0);
        chk("d3_cur_delay", 8'(cur_delay), 8'd3);
        chk("d3_settling", 8'(settling), 8'd1);
        for (int i = 1; i <= 10; i++) step(1, 0, 3, 1, W'(i));
        chk("d3_out_valid", 8'(out_valid), 8'd1);
        chk("d3_out_data", 8'(out_data), 8'd8);
        step(0, 0, 3, 1, 4'hB);
        chk("stall_hold", 8'(out_data), 8'd8);
        step(0, 0, 3, 1, 4'hC);
        for (int i = 11; i <= 15; i++) step(1, 0, 3, 1, W'(i));
        for (int i = 0; i <= 9; i++) step(1, 0, 5, 1, W'(i));
        for (int i = 0; i < 3; i++) step(1, 0, 0, 1, W'(i + 3));
        step(0, 0, 0, 1, 4'h9);
        chk("pass_data", 8'(out_data), 8'h9);
        step(0, 0, 0, 0, 4'h2);
        step(1, 0, 15, 1, 4'h1);
        chk("err_pulse", 8'(delay_err), 8'd1);
        chk("err_clamp", 8'(cur_delay), 8'd8);
        step(1, 0, 8, 1, 4'h2);
        chk("err_drop", 8'(delay_err), 8'd0);
        for (int i = 3; i <= 12; i++) step(1, 0, 8, 1, W'(i));
        step(1, 0, 4, 0, 4'h0);
        for (int i = 1; i <= 10; i++) step(1, 0, 4, 1, W'(i));
        step(1, 1, 4, 1, 4'hB);
        for (int i = 12; i <= 20; i++) step(1, 0, 4, 1, W'(i));
        step(1, 0, 6, 1, 4'h1);
        step(1, 0, 6, 1, 4'h2);
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            else step($urandom_range(0, 9) < 8, $urandom_range(0, 19) == 0,
                      ($urandom_range(0, 19) == 0) ? DW'($urandom_range(0, 15)) : delay_sel,
                      1'($urandom), W'($urandom));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
